// File: rtl/i2c_reg_sequencer.sv
// rtl/i2c_reg_sequencer.sv - turns one register read/write command into a full I2C byte sequence
// Optional watchdog: define I2C_SEQ_TIMEOUT_EN.
module i2c_reg_sequencer #(
  parameter int DATA_BYTES     = 2,
  parameter int TIMEOUT_CYCLES = 2**20
) (
  input  logic                    clk_in,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_rw,
  input  logic [6:0]              cmd_dev_addr,
  input  logic [7:0]              cmd_reg_addr,
  input  logic [8*DATA_BYTES-1:0] cmd_wdata,
  output logic                    rsp_valid,
  output logic [1:0]              rsp_status,
  output logic [8*DATA_BYTES-1:0] rsp_rdata,
  output logic                    transfer_start,
  output logic                    transfer_continues,
  output logic                    mode,
  output logic [7:0]              data_tx,
  input  logic                    transfer_ready,
  input  logic                    transaction_complete,
  input  logic                    nack,
  input  logic [7:0]              data_rx,
  input  logic                    start_err,
  input  logic                    arbitration_err
);
  localparam int DW = 8*DATA_BYTES;
  localparam logic [1:0] ST_OK   = 2'd0;
  localparam logic [1:0] ST_NACK = 2'd1;
  localparam logic [1:0] ST_ARB  = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_BUS, S_ADDR_W, S_REG, S_WDATA, S_ADDR_R, S_RDATA, S_STOP
  } state_t;

  state_t          state_q, state_d;
  logic            cmd_ready_q, cmd_ready_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [1:0]      status_q, status_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            start_q, start_d;
  logic            cont_q, cont_d;
  logic            mode_q, mode_d;
  logic [7:0]      data_tx_q, data_tx_d;
  logic            rw_q, rw_d;
  logic [6:0]      dev_q, dev_d;
  logic [7:0]      reg_q, reg_d;
  logic [DW-1:0]   wsh_q, wsh_d;
  logic [DW-1:0]   rsh_q, rsh_d;
  logic [2:0]      left_q, left_d;
  logic            last_byte;
  logic            nack_stop;

`ifdef I2C_SEQ_TIMEOUT_EN
  localparam logic [1:0] ST_TIMEOUT = 2'd3;
  localparam int WD_W = ($clog2(TIMEOUT_CYCLES) < 1) ? 1 : $clog2(TIMEOUT_CYCLES);
  logic [WD_W-1:0] wd_q, wd_d;
`endif

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = 1'b0;
    status_d    = status_q;
    rdata_d     = rdata_q;
    start_d     = start_q;
    cont_d      = cont_q;
    mode_d      = mode_q;
    data_tx_d   = data_tx_q;
    rw_d        = rw_q;
    dev_d       = dev_q;
    reg_d       = reg_q;
    wsh_d       = wsh_q;
    rsh_d       = rsh_q;
    left_d      = left_q;
    nack_stop   = 1'b0;
    last_byte   = (left_q == 3'd1);

    case (state_q)
      S_IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          rw_d        = cmd_rw;
          dev_d       = cmd_dev_addr;
          reg_d       = cmd_reg_addr;
          wsh_d       = cmd_wdata;
          left_d      = 3'(DATA_BYTES);
          status_d    = ST_OK;
          start_d     = 1'b1;
          cont_d      = 1'b1;
          mode_d      = 1'b0;
          data_tx_d   = {cmd_dev_addr, 1'b0};
          state_d     = S_WAIT_BUS;
        end
      end
      S_WAIT_BUS: begin
        if (transfer_ready) state_d = S_ADDR_W;
      end
      S_ADDR_W: begin
        if (transaction_complete) begin
          if (nack) nack_stop = 1'b1;
          else begin
            data_tx_d = reg_q;
            cont_d    = ~rw_q;  // read: repeated START after the register byte
            state_d   = S_REG;
          end
        end
      end
      S_REG: begin
        if (transaction_complete) begin
          if (nack) nack_stop = 1'b1;
          else if (rw_q) begin
            data_tx_d = {dev_q, 1'b1};
            cont_d    = 1'b1;
            state_d   = S_ADDR_R;
          end else begin
            data_tx_d = wsh_q[DW-1 -: 8];
            wsh_d     = wsh_q << 8;
            cont_d    = ~last_byte;
            state_d   = S_WDATA;
          end
        end
      end
      S_WDATA: begin
        if (transaction_complete) begin
          if (nack) nack_stop = 1'b1;
          else if (last_byte) begin
            start_d = 1'b0;
            cont_d  = 1'b0;
            state_d = S_STOP;
          end else begin
            data_tx_d = wsh_q[DW-1 -: 8];
            wsh_d     = wsh_q << 8;
            left_d    = left_q - 3'd1;
            cont_d    = (left_q > 3'd2);
          end
        end
      end
      S_ADDR_R: begin
        if (transaction_complete) begin
          if (nack) nack_stop = 1'b1;
          else begin
            mode_d  = 1'b1;
            cont_d  = ~last_byte;
            state_d = S_RDATA;
          end
        end
      end
      S_RDATA: begin
        if (transaction_complete) begin
          rsh_d = DW'({rsh_q, data_rx});
          if (last_byte) begin
            start_d = 1'b0;
            cont_d  = 1'b0;
            state_d = S_STOP;
          end else begin
            left_d = left_q - 3'd1;
            cont_d = (left_q > 3'd2);
          end
        end
      end
      S_STOP: begin
        if (transfer_ready) begin
          rsp_valid_d = 1'b1;
          mode_d      = 1'b0;
          state_d     = S_IDLE;
          if (rw_q && status_q == ST_OK) rdata_d = rsh_q;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // The core will not continue past a NACKed transmit byte; we only need to request STOP.
    if (nack_stop) begin
      start_d  = 1'b0;
      cont_d   = 1'b0;
      status_d = ST_NACK;
      state_d  = S_STOP;
    end

`ifdef I2C_SEQ_TIMEOUT_EN
    wd_d = wd_q;
    if (state_q == S_IDLE) begin
      if (cmd_valid && cmd_ready_q) wd_d = '0;
    end else if (transaction_complete) begin
      wd_d = '0;
    end else begin
      wd_d = wd_q + 1'b1;
    end
    if (state_q != S_IDLE && wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
      start_d     = 1'b0;
      cont_d      = 1'b0;
      mode_d      = 1'b0;
      status_d    = ST_TIMEOUT;
      rsp_valid_d = 1'b1;
      state_d     = S_IDLE;
    end
`endif

    // Errors win over everything; the core has already released the bus.
    if (state_q != S_IDLE && (start_err || arbitration_err)) begin
      start_d     = 1'b0;
      cont_d      = 1'b0;
      mode_d      = 1'b0;
      status_d    = ST_ARB;
      rsp_valid_d = 1'b1;
      state_d     = S_IDLE;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      status_q    <= ST_OK;
      rdata_q     <= '0;
      start_q     <= 1'b0;
      cont_q      <= 1'b0;
      mode_q      <= 1'b0;
      data_tx_q   <= 8'h00;
      rw_q        <= 1'b0;
      dev_q       <= 7'h00;
      reg_q       <= 8'h00;
      wsh_q       <= '0;
      rsh_q       <= '0;
      left_q      <= 3'd0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      status_q    <= status_d;
      rdata_q     <= rdata_d;
      start_q     <= start_d;
      cont_q      <= cont_d;
      mode_q      <= mode_d;
      data_tx_q   <= data_tx_d;
      rw_q        <= rw_d;
      dev_q       <= dev_d;
      reg_q       <= reg_d;
      wsh_q       <= wsh_d;
      rsh_q       <= rsh_d;
      left_q      <= left_d;
    end
  end

`ifdef I2C_SEQ_TIMEOUT_EN
  always_ff @(posedge clk_in) begin
    if (reset) wd_q <= '0;
    else       wd_q <= wd_d;
  end
`endif

  assign cmd_ready          = cmd_ready_q;
  assign rsp_valid          = rsp_valid_q;
  assign rsp_status         = status_q;
  assign rsp_rdata          = rdata_q;
  assign transfer_start     = start_q;
  assign transfer_continues = cont_q;
  assign mode               = mode_q;
  assign data_tx            = data_tx_q;

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// tb/tb_i2c_reg_sequencer.sv - directed bench with a behavioural byte-level core and one slave at 0x50
module tb_i2c_reg_sequencer;
  localparam int N = 2;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0, cmd_ready, cmd_rw = 1'b0;
  logic [6:0]    cmd_dev_addr = '0;
  logic [7:0]    cmd_reg_addr = '0;
  logic [8*N-1:0] cmd_wdata = '0;
  logic          rsp_valid;
  logic [1:0]    rsp_status;
  logic [8*N-1:0] rsp_rdata;
  logic          transfer_start, transfer_continues, mode;
  logic [7:0]    data_tx;
  logic          transfer_ready = 1'b1, transaction_complete = 1'b0, nack = 1'b0;
  logic [7:0]    data_rx = 8'h00;
  logic          start_err = 1'b0, arbitration_err = 1'b0;

  int total = 0;
  int bad = 0;

  i2c_reg_sequencer #(.DATA_BYTES(N), .TIMEOUT_CYCLES(1000)) dut (
    .clk_in(clk_in), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_dev_addr(cmd_dev_addr), .cmd_reg_addr(cmd_reg_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_status(rsp_status), .rsp_rdata(rsp_rdata),
    .transfer_start(transfer_start), .transfer_continues(transfer_continues),
    .mode(mode), .data_tx(data_tx),
    .transfer_ready(transfer_ready), .transaction_complete(transaction_complete),
    .nack(nack), .data_rx(data_rx), .start_err(start_err), .arbitration_err(arbitration_err)
  );

  // Bus log tokens: plain value = transmitted byte ACKed by slave.
  localparam int T_NACKED  = 'h100;
  localparam int T_RX_ACK  = 'h200;
  localparam int T_RX_NACK = 'h400;
  localparam int T_START   = 'h1000;
  localparam int T_SR      = 'h2000;
  localparam int T_STOP    = 'h4000;

  localparam int C_IDLE = 0, C_ACCEPT = 1, C_BUSY = 2, C_DECIDE = 3, C_STOP = 4;
  int         cst = C_IDLE;
  int         ccnt = 0;
  logic [7:0] cbyte = 8'h00;
  logic       cmode = 1'b0, ccont = 1'b0, caddr = 1'b0, cnack = 1'b0;
  int         byte_no = 0;
  int         arb_at = -1;
  logic       hold_scl = 1'b0;
  logic [7:0] rd_bytes [4];
  int         rd_idx = 0;
  int         bus_log[$];
  int         rv_count = 0;
  int         cyc = 0;
  int         tc_cyc = 0;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic core_launch();
    cbyte = data_tx; cmode = mode; ccont = transfer_continues;
    ccnt = 6; byte_no++; transfer_ready = 1'b0; cst = C_BUSY;
  endtask

  // Byte-level core model; it acts on negedges so the DUT sees stable inputs at posedge.
  always @(negedge clk_in) begin
    transaction_complete = 1'b0;
    arbitration_err = 1'b0;
    if (rsp_valid === 1'b1) rv_count++;
    case (cst)
      C_IDLE: begin
        transfer_ready = 1'b1;
        if (transfer_start === 1'b1) cst = C_ACCEPT;
      end
      C_ACCEPT: begin
        if (transfer_start !== 1'b1) cst = C_IDLE;
        else begin
          bus_log.push_back(T_START);
          byte_no = -1; rd_idx = 0; caddr = 1'b1;
          core_launch();
        end
      end
      C_BUSY: begin
        if (!hold_scl) ccnt--;
        if (arb_at == byte_no && ccnt == 3) begin
          arbitration_err = 1'b1; arb_at = -1;
          transfer_ready = 1'b1; cst = C_IDLE;
        end else if (ccnt == 0) begin
          transaction_complete = 1'b1;
          tc_cyc = cyc;
          if (!cmode) begin
            cnack = caddr && (cbyte[7:1] != 7'h50);
            nack = cnack;
            bus_log.push_back(cnack ? (T_NACKED | int'(cbyte)) : int'(cbyte));
          end else begin
            cnack = 1'b0; nack = 1'b0;
            data_rx = rd_bytes[rd_idx & 3]; rd_idx++;
            bus_log.push_back((ccont ? T_RX_ACK : T_RX_NACK) | int'(data_rx));
          end
          caddr = 1'b0; ccnt = 1; cst = C_DECIDE;
        end
      end
      C_DECIDE: begin
        nack = 1'b0;
        if (ccnt > 0) ccnt--;
        else if (transfer_start === 1'b1 && !cnack) begin
          if (!ccont) begin bus_log.push_back(T_SR); caddr = 1'b1; end
          core_launch();
        end else begin
          bus_log.push_back(T_STOP); ccnt = 3; cst = C_STOP;
        end
      end
      default: begin
        if (ccnt > 0) ccnt--;
        else begin transfer_ready = 1'b1; cst = C_IDLE; end
      end
    endcase
  end

  task automatic tick();
    @(negedge clk_in); #1;
  endtask

  task automatic send_cmd(input logic rw, input logic [6:0] dev, input logic [7:0] rg,
                          input logic [8*N-1:0] wd);
    for (int i = 0; i < 200 && cmd_ready !== 1'b1; i++) tick();
    cmd_rw = rw; cmd_dev_addr = dev; cmd_reg_addr = rg; cmd_wdata = wd; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output logic got, output logic [1:0] st);
    got = 1'b0; st = 2'd0;
    for (int i = 0; i < 500 && !got; i++) begin
      tick();
      if (rsp_valid === 1'b1) begin got = 1'b1; st = rsp_status; end
    end
  endtask

  task automatic wait_core_idle();
    for (int i = 0; i < 100 && cst != C_IDLE; i++) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; tick(); tick(); reset = 1'b0; tick();
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    total++; if (rsp_status !== 2'd0) begin bad++; $display("FAIL reset_rsp_status got=%0d exp=0", rsp_status); end
    total++; if (rsp_rdata !== 16'h0000) begin bad++; $display("FAIL reset_rsp_rdata got=%h exp=0000", rsp_rdata); end
    total++; if (transfer_start !== 1'b0) begin bad++; $display("FAIL reset_transfer_start got=%b exp=0", transfer_start); end
    total++; if (transfer_continues !== 1'b0) begin bad++; $display("FAIL reset_transfer_continues got=%b exp=0", transfer_continues); end
    total++; if (mode !== 1'b0) begin bad++; $display("FAIL reset_mode got=%b exp=0", mode); end
    total++; if (data_tx !== 8'h00) begin bad++; $display("FAIL reset_data_tx got=%h exp=00", data_tx); end
  endtask

  task automatic test_write();
    logic got; logic [1:0] st; int exp[$];
    bus_log.delete();
    send_cmd(1'b0, 7'h50, 8'h10, 16'hA55A);
    wait_rsp(got, st);
    total++; if (!got) begin bad++; $display("FAIL write_rsp got=none exp=pulse"); end
    total++; if (st !== 2'd0) begin bad++; $display("FAIL write_status got=%0d exp=0", st); end
    total++; if (rsp_rdata !== 16'h0000) begin bad++; $display("FAIL write_rdata got=%h exp=0000", rsp_rdata); end
    exp = '{T_START, 'hA0, 'h10, 'hA5, 'h5A, T_STOP};
    total++; if (bus_log.size() != exp.size()) begin bad++; $display("FAIL write_bus_len got=%0d exp=%0d", bus_log.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < bus_log.size(); i++) begin
      total++; if (bus_log[i] != exp[i]) begin bad++; $display("FAIL write_bus[%0d] got=%h exp=%h", i, bus_log[i], exp[i]); end
    end
    tick();
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL write_ready_after got=%b exp=1", cmd_ready); end
  endtask

  task automatic test_read();
    logic got; logic [1:0] st; int exp[$];
    bus_log.delete();
    rd_bytes[0] = 8'h12; rd_bytes[1] = 8'h34;
    send_cmd(1'b1, 7'h50, 8'h20, 16'h0000);
    wait_rsp(got, st);
    total++; if (!got) begin bad++; $display("FAIL read_rsp got=none exp=pulse"); end
    total++; if (st !== 2'd0) begin bad++; $display("FAIL read_status got=%0d exp=0", st); end
    total++; if (rsp_rdata !== 16'h1234) begin bad++; $display("FAIL read_rdata got=%h exp=1234", rsp_rdata); end
    exp = '{T_START, 'hA0, 'h20, T_SR, 'hA1, T_RX_ACK | 'h12, T_RX_NACK | 'h34, T_STOP};
    total++; if (bus_log.size() != exp.size()) begin bad++; $display("FAIL read_bus_len got=%0d exp=%0d", bus_log.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < bus_log.size(); i++) begin
      total++; if (bus_log[i] != exp[i]) begin bad++; $display("FAIL read_bus[%0d] got=%h exp=%h", i, bus_log[i], exp[i]); end
    end
  endtask

  task automatic test_addr_nack();
    logic got; logic [1:0] st; int exp[$]; int rv0;
    bus_log.delete();
    rv0 = rv_count;
    send_cmd(1'b0, 7'h51, 8'h10, 16'hFFFF);
    wait_rsp(got, st);
    for (int i = 0; i < 20; i++) tick();
    total++; if (st !== 2'd1) begin bad++; $display("FAIL nack_status got=%0d exp=1", st); end
    total++; if (rv_count - rv0 != 1) begin bad++; $display("FAIL nack_rsp_count got=%0d exp=1", rv_count - rv0); end
    total++; if (rsp_rdata !== 16'h1234) begin bad++; $display("FAIL nack_rdata_hold got=%h exp=1234", rsp_rdata); end
    exp = '{T_START, T_NACKED | 'hA2, T_STOP};
    total++; if (bus_log.size() != exp.size()) begin bad++; $display("FAIL nack_bus_len got=%0d exp=%0d", bus_log.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < bus_log.size(); i++) begin
      total++; if (bus_log[i] != exp[i]) begin bad++; $display("FAIL nack_bus[%0d] got=%h exp=%h", i, bus_log[i], exp[i]); end
    end
  endtask

  task automatic test_arb();
    logic seen = 1'b0;
    arb_at = 1;
    send_cmd(1'b0, 7'h50, 8'h30, 16'h1111);
    for (int i = 0; i < 200 && !seen; i++) begin
      tick();
      if (arbitration_err === 1'b1) seen = 1'b1;
    end
    total++; if (!seen) begin bad++; $display("FAIL arb_pulse got=none exp=pulse"); end
    tick();
    total++; if (transfer_start !== 1'b0) begin bad++; $display("FAIL arb_start_drop got=%b exp=0", transfer_start); end
    total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL arb_rsp_valid got=%b exp=1", rsp_valid); end
    total++; if (rsp_status !== 2'd2) begin bad++; $display("FAIL arb_status got=%0d exp=2", rsp_status); end
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL arb_ready_in_rsp got=%b exp=0", cmd_ready); end
    tick();
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL arb_ready_after got=%b exp=1", cmd_ready); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL arb_rsp_single got=%b exp=0", rsp_valid); end
    arb_at = -1;
    wait_core_idle();
  endtask

  task automatic test_back_to_back();
    logic got = 1'b0; logic [1:0] st;
    cmd_rw = 1'b0; cmd_dev_addr = 7'h50; cmd_reg_addr = 8'h40; cmd_wdata = 16'h0102;
    cmd_valid = 1'b1;
    for (int i = 0; i < 500 && !got; i++) begin
      tick();
      if (rsp_valid === 1'b1) got = 1'b1;
    end
    total++; if (!got) begin bad++; $display("FAIL b2b_first_rsp got=none exp=pulse"); end
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL b2b_ready_in_rsp got=%b exp=0", cmd_ready); end
    tick();
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_next got=%b exp=1", cmd_ready); end
    total++; if (transfer_start !== 1'b0) begin bad++; $display("FAIL b2b_not_yet got=%b exp=0", transfer_start); end
    tick();
    cmd_valid = 1'b0;
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL b2b_accepted got=%b exp=0", cmd_ready); end
    total++; if (transfer_start !== 1'b1) begin bad++; $display("FAIL b2b_started got=%b exp=1", transfer_start); end
    wait_rsp(got, st);
    total++; if (!got || st !== 2'd0) begin bad++; $display("FAIL b2b_second_rsp got=%b/%0d exp=1/0", got, st); end
  endtask

  task automatic test_reset_mid_read();
    logic got; logic [1:0] st; int exp[$]; int rv0; logic busy_rx = 1'b0;
    rd_bytes[0] = 8'hBE; rd_bytes[1] = 8'hEF;
    send_cmd(1'b1, 7'h50, 8'h20, 16'h0000);
    for (int i = 0; i < 300 && !busy_rx; i++) begin
      tick();
      if (cst == C_BUSY && cmode) busy_rx = 1'b1;
    end
    total++; if (!busy_rx) begin bad++; $display("FAIL midrst_reach_rdata got=0 exp=1"); end
    reset = 1'b1; tick(); reset = 1'b0;
    rv0 = rv_count;
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL midrst_cmd_ready got=%b exp=1", cmd_ready); end
    total++; if (transfer_start !== 1'b0) begin bad++; $display("FAIL midrst_start got=%b exp=0", transfer_start); end
    total++; if (rsp_rdata !== 16'h0000) begin bad++; $display("FAIL midrst_rdata got=%h exp=0000", rsp_rdata); end
    wait_core_idle();
    tick();
    total++; if (rv_count != rv0) begin bad++; $display("FAIL midrst_no_rsp got=%0d exp=0", rv_count - rv0); end
    bus_log.delete();
    rd_bytes[0] = 8'h5A; rd_bytes[1] = 8'hC3;
    send_cmd(1'b1, 7'h50, 8'h20, 16'h0000);
    wait_rsp(got, st);
    total++; if (!got || st !== 2'd0) begin bad++; $display("FAIL midrst_next_rsp got=%b/%0d exp=1/0", got, st); end
    total++; if (rsp_rdata !== 16'h5AC3) begin bad++; $display("FAIL midrst_next_rdata got=%h exp=5ac3", rsp_rdata); end
    exp = '{T_START, 'hA0, 'h20, T_SR, 'hA1, T_RX_ACK | 'h5A, T_RX_NACK | 'hC3, T_STOP};
    total++; if (bus_log.size() != exp.size()) begin bad++; $display("FAIL midrst_bus_len got=%0d exp=%0d", bus_log.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < bus_log.size(); i++) begin
      total++; if (bus_log[i] != exp[i]) begin bad++; $display("FAIL midrst_bus[%0d] got=%h exp=%h", i, bus_log[i], exp[i]); end
    end
  endtask

`ifdef I2C_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    logic got = 1'b0; logic [1:0] st = 2'd0; logic held = 1'b0; int dt = 0;
    send_cmd(1'b0, 7'h50, 8'h60, 16'h0000);
    for (int i = 0; i < 200 && !held; i++) begin
      tick();
      if (cst == C_BUSY && byte_no == 1) begin hold_scl = 1'b1; held = 1'b1; end
    end
    for (int i = 0; i < 1200 && !got; i++) begin
      tick();
      if (rsp_valid === 1'b1) begin got = 1'b1; st = rsp_status; dt = cyc - tc_cyc - 1; end
    end
    total++; if (!got || st !== 2'd3) begin bad++; $display("FAIL timeout_status got=%b/%0d exp=1/3", got, st); end
    total++; if (dt != 1000) begin bad++; $display("FAIL timeout_latency got=%0d exp=1000", dt); end
    hold_scl = 1'b0;
    wait_core_idle();
  endtask
`endif

  initial begin
    #300000;
    $display("FAIL global_watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write();
    test_read();
    test_addr_nack();
    test_arb();
    test_back_to_back();
    test_reset_mid_read();
`ifdef I2C_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
